// File: rtl/pps_timing_pkg.sv
// pps_timing_pkg
//   Shared types and constants for the PPS timing core.
//   stop_state_e : per-channel stop-sequence state (IDLE/ARM/STOP/WAIT)
//   AdjClampDiv  : phase adjustments are clamped to +/- ClocksPerSecond/AdjClampDiv
package pps_timing_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_STOP = 2'd2,
      ST_WAIT = 2'd3
   } stop_state_e;

   localparam int unsigned AdjClampDiv = 4;

endpackage

// File: rtl/pps_channel.sv
// pps_channel
//   One raw-PPS channel: synchronizer, edge detect, stop-sequence FSM,
//   second-counter capture and sticky missing-pulse flag.
//   Ports:
//     clk_tf, rst        : clock, synchronous active-high reset
//     pps_raw            : asynchronous raw PPS for this channel
//     wrap               : second counter is at its terminal count this cycle
//     sec_count_next     : second count that will be current next cycle
//     slow_rise_next     : slow clock rises on the next edge
//     slow_fall_next     : slow clock falls on the next edge
//     slow_next          : unregistered slow clock level
//     tdc_stop_next      : TDC stop, unregistered (next state is STOP)
//     stop_tos_count     : registered gated slow clock
//     cap_valid          : one-cycle capture strobe
//     cap_count          : captured second count
//     no_pulse           : sticky "no PPS seen during a whole second"
module pps_channel
   import pps_timing_pkg::*;
#(
   parameter int CountW = 25
) (
   input  logic              clk_tf,
   input  logic              rst,
   input  logic              pps_raw,
   input  logic              wrap,
   input  logic [CountW-1:0] sec_count_next,
   input  logic              slow_rise_next,
   input  logic              slow_fall_next,
   input  logic              slow_next,
   output logic              tdc_stop_next,
   output logic              stop_tos_count,
   output logic              cap_valid,
   output logic [CountW-1:0] cap_count,
   output logic              no_pulse
);

   // sync_q[0], sync_q[1] form the synchronizer; sync_q[2] is the delay flop
   logic [2:0]        sync_q, sync_d;
   stop_state_e       state_q, state_d;
   logic              stop_tos_q, stop_tos_d;
   logic              cap_valid_q, cap_valid_d;
   logic [CountW-1:0] cap_count_q, cap_count_d;
   logic              no_pulse_q, no_pulse_d;
   logic              rise;
   logic              capture;

   assign rise = sync_q[1] & ~sync_q[2];

   always_comb begin
      sync_d        = {sync_q[1:0], pps_raw};
      state_d       = state_q;
      cap_valid_d   = 1'b0;
      cap_count_d   = cap_count_q;
      no_pulse_d    = no_pulse_q;
      capture       = 1'b0;

      case (state_q)
         ST_IDLE: if (rise)           state_d = ST_ARM;
         ST_ARM:  if (slow_rise_next) state_d = ST_STOP;
         ST_STOP: if (slow_fall_next) state_d = ST_WAIT;
         ST_WAIT: if (wrap)           state_d = ST_IDLE;
         default:                     state_d = ST_IDLE;
      endcase

      // Rises outside IDLE belong to a sequence already in flight and are dropped
      capture = (state_q == ST_IDLE) && rise;

      if (wrap && (state_q == ST_IDLE)) begin
         no_pulse_d = 1'b1;
      end

      // The stored count is the one current while cap_valid is high, i.e. three
      // counts after the raw edge (two sync flops plus the delay flop).
      // A capture in the wrap cycle overrides setting no_pulse.
      if (capture) begin
         cap_valid_d = 1'b1;
         cap_count_d = sec_count_next;
         no_pulse_d  = 1'b0;
      end

      tdc_stop_next = (state_d == ST_STOP);
      stop_tos_d    = ((state_d == ST_IDLE) || (state_d == ST_ARM)) ? slow_next : 1'b0;
   end

   always_ff @(posedge clk_tf) begin
      if (rst) begin
         sync_q      <= '0;
         state_q     <= ST_IDLE;
         stop_tos_q  <= 1'b1;
         cap_valid_q <= 1'b0;
         cap_count_q <= '0;
         no_pulse_q  <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         stop_tos_q  <= stop_tos_d;
         cap_valid_q <= cap_valid_d;
         cap_count_q <= cap_count_d;
         no_pulse_q  <= no_pulse_d;
      end
   end

   assign stop_tos_count = stop_tos_q;
   assign cap_valid      = cap_valid_q;
   assign cap_count      = cap_count_q;
   assign no_pulse       = no_pulse_q;

endmodule

// File: rtl/pps_timing_core.sv
// pps_timing_core
//   Local second counter with phase adjust, clean PPS generation, a free
//   running slow clock, and NumChannels raw-PPS capture channels.
//   Ports:
//     clk_tf, rst     : only clock, synchronous active-high reset
//     pps_raw         : asynchronous raw PPS inputs, one per channel
//     adj_valid/ready : phase-adjust handshake (ready = nothing pending)
//     adj_delta       : signed cycles added to the next full second
//     tos_mark_ddc    : next clk_tf edge is top of second
//     pps_clean_next  : unregistered clean PPS; pps_clean_uc is its register
//     tdc_stop_next   : per-channel TDC stop (unregistered)
//     stop_tos_count  : per-channel gated slow clock (registered)
//     cap_valid/count : per-channel capture strobe and captured second count
//     no_pulse        : per-channel sticky missing-PPS flag
module pps_timing_core
   import pps_timing_pkg::*;
#(
   parameter int ClocksPerSecond = 19200000,
   parameter int PpsPulseWidth   = 1920,
   parameter int SlowClockPeriod = 1920,
   parameter int NumChannels     = 2,
   localparam int CountW         = $clog2(ClocksPerSecond + ClocksPerSecond / 4)
) (
   input  logic                          clk_tf,
   input  logic                          rst,
   input  logic [NumChannels-1:0]        pps_raw,
   input  logic                          adj_valid,
   input  logic signed [CountW:0]        adj_delta,
   output logic                          adj_ready,
   output logic                          tos_mark_ddc,
   output logic                          pps_clean_next,
   output logic                          pps_clean_uc,
   output logic [NumChannels-1:0]        tdc_stop_next,
   output logic [NumChannels-1:0]        stop_tos_count,
   output logic [NumChannels-1:0]        cap_valid,
   output logic [NumChannels*CountW-1:0] cap_count,
   output logic [NumChannels-1:0]        no_pulse
);

   localparam int SlowW    = $clog2(SlowClockPeriod);
   localparam int DeltaMax = ClocksPerSecond / AdjClampDiv;

   localparam logic [CountW-1:0]       TermNom  = CountW'(ClocksPerSecond - 1);
   localparam logic [CountW-1:0]       PulseW   = CountW'(PpsPulseWidth);
   localparam logic signed [CountW:0]  DeltaHi  = (CountW + 1)'(DeltaMax);
   localparam logic signed [CountW:0]  DeltaLo  = -DeltaHi;
   localparam logic [SlowW-1:0]        SlowLast = SlowW'(SlowClockPeriod - 1);
   localparam logic [SlowW-1:0]        SlowHalf = SlowW'(SlowClockPeriod / 2 - 1);

   // The clamped delta fits in CountW signed bits because 2^(CountW-1)
   // exceeds ClocksPerSecond/4 for any ClocksPerSecond.
   function automatic logic signed [CountW-1:0] sat_delta(input logic signed [CountW:0] d);
      if (d > DeltaHi) begin
         sat_delta = DeltaHi[CountW-1:0];
      end else if (d < DeltaLo) begin
         sat_delta = DeltaLo[CountW-1:0];
      end else begin
         sat_delta = d[CountW-1:0];
      end
   endfunction

   logic [CountW-1:0]        count_q, count_d;
   logic [SlowW-1:0]         slow_q, slow_d;
   logic signed [CountW-1:0] applied_q, applied_d;
   logic signed [CountW-1:0] pend_delta_q, pend_delta_d;
   logic                     pend_q, pend_d;
   logic                     pps_clean_uc_q, pps_clean_uc_d;
   logic [CountW-1:0]        term;
   logic                     wrap;
   logic                     slow_rise_next;
   logic                     slow_fall_next;
   logic                     slow_next;

   // Modular add: the true term always lies in 0..2^CountW-1
   assign term = TermNom + $unsigned(applied_q);
   assign wrap = (count_q == term);

   assign slow_rise_next = (slow_q == SlowLast);
   assign slow_fall_next = (slow_q == SlowHalf);
   assign slow_next      = (slow_q < SlowHalf) || slow_rise_next;

   assign adj_ready      = ~pend_q;
   assign tos_mark_ddc   = wrap;
   assign pps_clean_next = (count_q < PulseW) || wrap;
   assign pps_clean_uc   = pps_clean_uc_q;

   always_comb begin
      count_d        = wrap ? '0 : count_q + CountW'(1);
      slow_d         = slow_rise_next ? '0 : slow_q + SlowW'(1);
      applied_d      = applied_q;
      pend_d         = pend_q;
      pend_delta_d   = pend_delta_q;
      pps_clean_uc_d = pps_clean_next;

      // A pending delta lengthens/shortens only the second that starts now
      if (wrap) begin
         applied_d = pend_q ? pend_delta_q : '0;
         pend_d    = 1'b0;
      end

      // Evaluated after the wrap update so an adjust accepted in the wrap
      // cycle stays pending for the following wrap
      if (adj_valid && adj_ready) begin
         pend_d       = 1'b1;
         pend_delta_d = sat_delta(adj_delta);
      end
   end

   always_ff @(posedge clk_tf) begin
      if (rst) begin
         count_q        <= '0;
         slow_q         <= '0;
         applied_q      <= '0;
         pend_q         <= 1'b0;
         pend_delta_q   <= '0;
         pps_clean_uc_q <= 1'b1;
      end else begin
         count_q        <= count_d;
         slow_q         <= slow_d;
         applied_q      <= applied_d;
         pend_q         <= pend_d;
         pend_delta_q   <= pend_delta_d;
         pps_clean_uc_q <= pps_clean_uc_d;
      end
   end

   for (genvar ch = 0; ch < NumChannels; ch++) begin : g_ch
      pps_channel #(
         .CountW(CountW)
      ) u_channel (
         .clk_tf        (clk_tf),
         .rst           (rst),
         .pps_raw       (pps_raw[ch]),
         .wrap          (wrap),
         .sec_count_next(count_d),
         .slow_rise_next(slow_rise_next),
         .slow_fall_next(slow_fall_next),
         .slow_next     (slow_next),
         .tdc_stop_next (tdc_stop_next[ch]),
         .stop_tos_count(stop_tos_count[ch]),
         .cap_valid     (cap_valid[ch]),
         .cap_count     (cap_count[ch*CountW +: CountW]),
         .no_pulse      (no_pulse[ch])
      );
   end

endmodule

// File: tb/tb_pps_timing_core.sv
// tb_pps_timing_core
//   Directed stimulus on a cycle schedule; expected top-of-second and capture
//   events are queued when the stimulus is issued and a separate monitor pops
//   them whenever the DUT strobes tos_mark_ddc or cap_valid.
module tb_pps_timing_core;

   localparam int Cps = 100;
   localparam int Pw  = 10;
   localparam int Sp  = 20;
   localparam int Nc  = 2;
   localparam int CW  = $clog2(Cps + Cps / 4);

   logic                 clk_tf = 1'b0;
   logic                 rst = 1'b1;
   logic [Nc-1:0]        pps_raw = '0;
   logic                 adj_valid = 1'b0;
   logic signed [CW:0]   adj_delta = '0;
   logic                 adj_ready;
   logic                 tos_mark_ddc;
   logic                 pps_clean_next;
   logic                 pps_clean_uc;
   logic [Nc-1:0]        tdc_stop_next;
   logic [Nc-1:0]        stop_tos_count;
   logic [Nc-1:0]        cap_valid;
   logic [Nc*CW-1:0]     cap_count;
   logic [Nc-1:0]        no_pulse;

   always #5 clk_tf = ~clk_tf;

   pps_timing_core #(
      .ClocksPerSecond(Cps),
      .PpsPulseWidth  (Pw),
      .SlowClockPeriod(Sp),
      .NumChannels    (Nc)
   ) dut (
      .clk_tf        (clk_tf),
      .rst           (rst),
      .pps_raw       (pps_raw),
      .adj_valid     (adj_valid),
      .adj_delta     (adj_delta),
      .adj_ready     (adj_ready),
      .tos_mark_ddc  (tos_mark_ddc),
      .pps_clean_next(pps_clean_next),
      .pps_clean_uc  (pps_clean_uc),
      .tdc_stop_next (tdc_stop_next),
      .stop_tos_count(stop_tos_count),
      .cap_valid     (cap_valid),
      .cap_count     (cap_count),
      .no_pulse      (no_pulse)
   );

   typedef struct {
      int ch;
      int t;
      int val;
   } cap_exp_t;

   int       exp_tos[$];
   cap_exp_t exp_cap[$];
   cap_exp_t mon_e;

   int t = 0;
   int checks = 0;
   int errors = 0;

   // Cycles since reset release: equals the DUT second count until the first wrap
   always @(posedge clk_tf) t <= rst ? 0 : t + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at t=%0d: got %0d, expected %0d", name, t, act, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_pps_clean_uc"},   int'(pps_clean_uc), 1);
      check({tag, "_stop_tos_count"}, int'(stop_tos_count), 3);
      check({tag, "_adj_ready"},      int'(adj_ready), 1);
      check({tag, "_cap_valid"},      int'(cap_valid), 0);
      check({tag, "_cap_count"},      int'(cap_count), 0);
      check({tag, "_no_pulse"},       int'(no_pulse), 0);
      check({tag, "_tdc_stop_next"},  int'(tdc_stop_next), 0);
      check({tag, "_tos_mark_ddc"},   int'(tos_mark_ddc), 0);
   endtask

   // Monitor: every strobe must match the next queued expectation
   always @(negedge clk_tf) begin
      if (tos_mark_ddc === 1'b1) begin
         if (exp_tos.size() == 0) check("tos_mark_ddc_unexpected", t, -1);
         else                     check("tos_mark_ddc_time", t, exp_tos.pop_front());
      end
      for (int ch = 0; ch < Nc; ch++) begin
         if (cap_valid[ch] === 1'b1) begin
            if (exp_cap.size() == 0) begin
               check("cap_valid_unexpected", t, -1);
            end else begin
               mon_e = exp_cap.pop_front();
               check("cap_channel", ch, mon_e.ch);
               check("cap_time", t, mon_e.t);
               check("cap_count", int'(cap_count[ch*CW +: CW]), mon_e.val);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got t=%0d, expected completion", t);
      $fatal(1, "watchdog");
   end

   initial begin
      // Seconds: 0..99, 100..199 (+7 accepted), 200..306, 307..406 (clamped -25),
      // 407..481, 482..581 (+3 accepted on wrap), 582..681, 682..784
      exp_tos = '{99, 199, 306, 406, 481, 581, 681, 784};

      repeat (3) @(negedge clk_tf);
      check_reset_values("reset_initial");
      rst = 1'b0;

      for (int k = 0; k <= 795; k++) begin
         if (k <= 120)
            check("pps_clean_uc", int'(pps_clean_uc), (k <= 10 || (k >= 100 && k <= 110)) ? 1 : 0);
         if (k >= 50 && k <= 75) begin
            check("tdc_stop_next0", int'(tdc_stop_next[0]), (k >= 59 && k <= 68) ? 1 : 0);
            check("tdc_stop_next1", int'(tdc_stop_next[1]), 0);
         end
         if (k >= 59 && k <= 100)
            check("stop_tos_count0", int'(stop_tos_count[0]), (k == 100) ? 1 : 0);

         case (k)
            40: begin
               pps_raw[0] = 1'b1;
               exp_cap.push_back('{0, 43, 43});
            end
            45: pps_raw[0] = 1'b0;
            // Second edge while ch0 is in WAIT: must not capture
            80: pps_raw[0] = 1'b1;
            85: pps_raw[0] = 1'b0;
            100: begin
               check("no_pulse1_set", int'(no_pulse[1]), 1);
               check("no_pulse0_kept", int'(no_pulse[0]), 0);
            end
            120: begin
               pps_raw[1] = 1'b1;
               exp_cap.push_back('{1, 123, 23});
            end
            122: check("no_pulse1_before_cap", int'(no_pulse[1]), 1);
            123: check("no_pulse1_cleared", int'(no_pulse[1]), 0);
            125: pps_raw[1] = 1'b0;
            150: begin
               check("adj_ready_idle", int'(adj_ready), 1);
               adj_valid = 1'b1;
               adj_delta = 9'sd7;
            end
            151: begin
               adj_valid = 1'b0;
               check("adj_ready_pending", int'(adj_ready), 0);
            end
            199: check("adj_ready_at_wrap", int'(adj_ready), 0);
            200: begin
               check("adj_ready_after_wrap", int'(adj_ready), 1);
               check("no_pulse0_second1", int'(no_pulse[0]), 1);
               check("no_pulse1_second1", int'(no_pulse[1]), 0);
            end
            // -200 is outside the 8-bit adj_delta range; full-scale -128 exercises the same clamp
            317: begin
               adj_valid = 1'b1;
               adj_delta = -9'sd128;
            end
            318: begin
               adj_valid = 1'b0;
               check("adj_ready_neg_pending", int'(adj_ready), 0);
            end
            406: check("adj_ready_neg_at_wrap", int'(adj_ready), 0);
            407: check("adj_ready_neg_after", int'(adj_ready), 1);
            581: begin
               check("adj_ready_wrap_accept", int'(adj_ready), 1);
               adj_valid = 1'b1;
               adj_delta = 9'sd3;
            end
            582: begin
               adj_valid = 1'b0;
               check("adj_ready_wrap_pending", int'(adj_ready), 0);
            end
            788: begin
               adj_valid = 1'b1;
               adj_delta = 9'sd5;
            end
            789: begin
               adj_valid = 1'b0;
               check("adj_ready_before_rst", int'(adj_ready), 0);
            end
            790: begin
               pps_raw[0] = 1'b1;
               exp_cap.push_back('{0, 793, 8});
            end
            794: begin
               check("no_pulse1_before_rst", int'(no_pulse[1]), 1);
               check("no_pulse0_cleared_by_cap", int'(no_pulse[0]), 0);
            end
            // ch0 is in ARM here (rise at 792, slow rise not until 799)
            795: begin
               rst = 1'b1;
               pps_raw[0] = 1'b0;
            end
            default: ;
         endcase
         @(negedge clk_tf);
      end

      check_reset_values("reset_mid_arm");
      rst = 1'b0;
      // Pending +5 must have been discarded: both seconds are nominal
      exp_tos.push_back(99);
      exp_tos.push_back(199);
      repeat (206) @(negedge clk_tf);

      check("tos_events_outstanding", exp_tos.size(), 0);
      check("cap_events_outstanding", exp_cap.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pps_timing_core.md
PPS_TIMING_CORE -- requirements
Module: pps_timing_core

Interface
REQ-001 SHALL have parameter ClocksPerSecond, default 19200000, meaning nominal clk_tf cycles per second.
REQ-002 SHALL have parameter PpsPulseWidth, default 1920, meaning clean PPS high time in cycles.
REQ-003 SHALL have parameter SlowClockPeriod, default 1920 (even), meaning slow-clock period in cycles.
REQ-004 SHALL have parameter NumChannels, default 2, meaning number of raw PPS inputs.
REQ-005 SHALL derive CountW = clog2(ClocksPerSecond + ClocksPerSecond/4), meaning second-counter width.
REQ-006 SHALL have port clk_tf, input, 1, meaning the only clock.
REQ-007 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-008 SHALL have port pps_raw, input, NumChannels, meaning asynchronous raw PPS inputs.
REQ-009 SHALL have port adj_valid, input, 1, meaning phase-adjust request.
REQ-010 SHALL have port adj_delta, input, CountW+1 signed, meaning cycles to add to the next second.
REQ-011 SHALL have port adj_ready, output, 1, meaning no adjust pending.
REQ-012 SHALL have port tos_mark_ddc, output, 1, meaning the next clk_tf edge is top of second.
REQ-013 SHALL have port pps_clean_next, output, 1, meaning the unregistered clean PPS.
REQ-014 SHALL have port pps_clean_uc, output, 1, meaning registered clean PPS.
REQ-015 SHALL have port tdc_stop_next, output, NumChannels, meaning per-channel TDC stop, unregistered.
REQ-016 SHALL have port stop_tos_count, output, NumChannels, meaning per-channel gated slow clock, registered.
REQ-017 SHALL have port cap_valid, output, NumChannels, meaning 1-cycle capture strobe.
REQ-018 SHALL have port cap_count, output, NumChannels*CountW, meaning captured second-counter value per channel.
REQ-019 SHALL have port no_pulse, output, NumChannels, meaning sticky missing-PPS flag.

Function
REQ-020 SHALL run a second counter from 0 to term, where term = ClocksPerSecond-1+applied_delta, then wrap to 0.
REQ-021 SHALL assert tos_mark_ddc exactly when count==term.
REQ-022 SHALL drive pps_clean_next = (count < PpsPulseWidth) or (count == term), and register it into pps_clean_uc.
REQ-023 SHALL accept an adjust when adj_valid && adj_ready; SHALL saturate the delta to ±ClocksPerSecond/4 and hold it pending, with adj_ready low.
REQ-024 SHALL apply a pending delta only to the second starting at the next wrap, then clear pending; applied_delta SHALL return to 0 for the following second.
REQ-025 SHALL accept an adjust in the wrap cycle and apply it at the following wrap.
REQ-026 SHALL run a free slow-clock counter 0..SlowClockPeriod-1; rise_next at SlowClockPeriod-1; fall_next at SlowClockPeriod/2-1; slow_next high when count < SlowClockPeriod/2-1 or count == SlowClockPeriod-1.
REQ-027 SHALL pass each pps_raw bit through a 2-flop synchronizer plus one delay flop; rise = d2 && !d3.
REQ-028 SHALL give each channel its own FSM: IDLE -rise-> ARM -slow rise_next-> STOP -slow fall_next-> WAIT -second wrap (count==term)-> IDLE.
REQ-029 SHALL drive tdc_stop_next[ch] = (next state == STOP).
REQ-030 SHALL register stop_tos_count[ch] as slow_next when the next state is IDLE or ARM, and 0 otherwise.
REQ-031 SHALL, on a rise while in IDLE, load cap_count[ch] with the current second count (uncompensated; software subtracts 3) and pulse cap_valid[ch] for one cycle.
REQ-032 SHALL ignore rises in ARM, STOP or WAIT, with no capture.
REQ-033 SHALL set no_pulse[ch] at a wrap if the channel is in IDLE, and clear it on that channel's next capture; if capture and wrap coincide, the capture wins.

Reset
REQ-034 SHALL, on reset, clear the second and slow counters, pending/applied delta and sync flops, put all FSMs in IDLE, and clear cap_count, cap_valid and no_pulse.
REQ-035 SHALL reset pps_clean_uc=1, stop_tos_count=all 1, adj_ready=1; reset SHALL discard a mid-second pending adjust.

Structure
REQ-036 SHALL place the stop-FSM state enum and the clamp helper constant in package pps_timing_pkg.
REQ-037 SHALL implement per-channel sync, FSM, capture and no_pulse in sub-module pps_channel, instantiated NumChannels times by generate.

Verification (ClocksPerSecond=100, PpsPulseWidth=10, SlowClockPeriod=20, NumChannels=2)
REQ-038 SHALL verify: free run from reset -> tos_mark_ddc every 100 cycles at count 99; pps_clean_uc high 11 cycles from count 99 through 9.
REQ-039 SHALL verify: ch0 raw edge at count 40 -> cap_count=43, cap_valid pulse; tdc_stop_next high counts 59..68; stop_tos_count[0] is 0 from count 59 to wrap.
REQ-040 SHALL verify: adj_delta=+7 accepted at count 50 -> next second wraps at count 106, then 99 again; adj_ready low from acceptance until the wrap.
REQ-041 SHALL verify: adj_delta=-200 -> saturated to -25; that second's term=74.
REQ-042 SHALL verify: ch1 idle for a whole second -> no_pulse[1]=1 at wrap; cleared by the next capture; ch0 unaffected.
REQ-043 SHALL verify: second raw edge at count 80 while in STOP/WAIT -> no capture; rst asserted mid-ARM -> IDLE and outputs at reset values next cycle.
